// File: rtl/tri_pkg.sv
// Shared types and constants for the triangle bounding-box scanner.
// Optional statistics outputs are enabled with the TRI_SCAN_STATS_EN macro.
package tri_pkg;

   localparam int COORD_W      = 11;
   localparam int SCREEN_W_DEF = 640;
   localparam int SCREEN_H_DEF = 480;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      coord_t min_x;
      coord_t max_x;
      coord_t min_y;
      coord_t max_y;
   } bbox_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SCAN  = 2'd2
   } scan_state_t;

   function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
      coord_t m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
      coord_t m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

endpackage

// File: rtl/tri_bbox.sv
// One axis of the bounding box: min/max of three coordinates, max clipped
// to LIMIT-1, empty when the whole span lies beyond the screen edge.
module tri_bbox
   import tri_pkg::*;
#(
   parameter int LIMIT = SCREEN_W_DEF
) (
   input  coord_t a_i,
   input  coord_t b_i,
   input  coord_t c_i,
   input  coord_t unused_pad_i,
   output coord_t lo_o,
   output coord_t hi_o,
   output logic   empty_o
);

   localparam coord_t EDGE = coord_t'(LIMIT - 1);

   coord_t raw_hi;
   logic   pad_unused;

   assign pad_unused = |unused_pad_i;
   assign lo_o       = min3(a_i, b_i, c_i);
   assign raw_hi     = max3(a_i, b_i, c_i);
   assign hi_o       = (raw_hi > EDGE) ? EDGE : raw_hi;
   assign empty_o    = (lo_o > EDGE) || (pad_unused && 1'b0);

endmodule

// File: rtl/tri_bbox_scanner.sv
// Accepts a triangle, clips its bounding box to the screen and streams every
// candidate pixel in raster order. Optional stats: TRI_SCAN_STATS_EN.
module tri_bbox_scanner
   import tri_pkg::*;
#(
   parameter int SCREEN_W = SCREEN_W_DEF,
   parameter int SCREEN_H = SCREEN_H_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tri_valid,
   output logic               tri_ready,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   input  logic [COORD_W-1:0] x2,
   input  logic [COORD_W-1:0] y2,
   input  logic [COORD_W-1:0] x3,
   input  logic [COORD_W-1:0] y3,
   output logic [COORD_W-1:0] tri_x1,
   output logic [COORD_W-1:0] tri_y1,
   output logic [COORD_W-1:0] tri_x2,
   output logic [COORD_W-1:0] tri_y2,
   output logic [COORD_W-1:0] tri_x3,
   output logic [COORD_W-1:0] tri_y3,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic               pix_last,
   output logic               busy,
`ifdef TRI_SCAN_STATS_EN
   output logic [2*COORD_W-1:0] pix_count,
   output logic [15:0]          max_stall,
`endif
   output logic               done
);

   scan_state_t state_q, state_d;

   coord_t tx1_q, ty1_q, tx2_q, ty2_q, tx3_q, ty3_q;
   coord_t pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic   done_q, done_d;

   bbox_t  box;
   logic   empty_x, empty_y, box_empty;
   logic   accept, pix_hs, at_end;

   // The box is derived from the registered vertices, which stay put until
   // the next acceptance, so it is valid throughout SETUP and SCAN.
   tri_bbox #(.LIMIT(SCREEN_W)) u_bbox_x (
      .a_i(tx1_q), .b_i(tx2_q), .c_i(tx3_q), .unused_pad_i('0),
      .lo_o(box.min_x), .hi_o(box.max_x), .empty_o(empty_x)
   );

   tri_bbox #(.LIMIT(SCREEN_H)) u_bbox_y (
      .a_i(ty1_q), .b_i(ty2_q), .c_i(ty3_q), .unused_pad_i('0),
      .lo_o(box.min_y), .hi_o(box.max_y), .empty_o(empty_y)
   );

   assign box_empty = empty_x || empty_y;
   assign accept    = tri_valid && tri_ready;
   assign pix_hs    = pix_valid && pix_ready;
   assign at_end    = (pix_x_q == box.max_x) && (pix_y_q == box.max_y);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (tri_valid) state_d = SETUP;
         SETUP:   state_d = box_empty ? IDLE : SCAN;
         SCAN:    if (pix_ready && at_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      tri_ready = (state_q == IDLE);
      busy      = (state_q != IDLE);
      pix_valid = (state_q == SCAN);
      pix_last  = (state_q == SCAN) && at_end;
   end

   // Pixel walk
   always_comb begin
      pix_x_d = pix_x_q;
      pix_y_d = pix_y_q;
      done_d  = 1'b0;
      case (state_q)
         SETUP: begin
            if (box_empty) begin
               done_d = 1'b1;
            end else begin
               pix_x_d = box.min_x;
               pix_y_d = box.min_y;
            end
         end
         SCAN: begin
            if (pix_hs) begin
               if (at_end) begin
                  done_d = 1'b1;
               end else if (pix_x_q == box.max_x) begin
                  pix_x_d = box.min_x;
                  pix_y_d = pix_y_q + coord_t'(1);
               end else begin
                  pix_x_d = pix_x_q + coord_t'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx1_q   <= '0;
         ty1_q   <= '0;
         tx2_q   <= '0;
         ty2_q   <= '0;
         tx3_q   <= '0;
         ty3_q   <= '0;
         pix_x_q <= '0;
         pix_y_q <= '0;
         done_q  <= 1'b0;
      end else begin
         if (accept) begin
            tx1_q <= x1;
            ty1_q <= y1;
            tx2_q <= x2;
            ty2_q <= y2;
            tx3_q <= x3;
            ty3_q <= y3;
         end
         pix_x_q <= pix_x_d;
         pix_y_q <= pix_y_d;
         done_q  <= done_d;
      end
   end

   assign tri_x1 = tx1_q;
   assign tri_y1 = ty1_q;
   assign tri_x2 = tx2_q;
   assign tri_y2 = ty2_q;
   assign tri_x3 = tx3_q;
   assign tri_y3 = ty3_q;
   assign pix_x  = pix_x_q;
   assign pix_y  = pix_y_q;
   assign done   = done_q;

`ifdef TRI_SCAN_STATS_EN
   logic [2*COORD_W-1:0] cnt_q, cnt_d;
   logic [15:0]          run_q, run_d, max_q, max_d, run_inc;
   logic                 stall;

   assign stall   = pix_valid && !pix_ready;
   assign run_inc = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;

   always_comb begin
      cnt_d = cnt_q;
      run_d = run_q;
      max_d = max_q;
      if (accept) begin
         cnt_d = '0;
         run_d = '0;
         max_d = '0;
      end else begin
         if (pix_hs) cnt_d = cnt_q + 1'b1;
         if (stall) begin
            run_d = run_inc;
            if (run_inc > max_q) max_d = run_inc;
         end else begin
            run_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         run_q <= '0;
         max_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         run_q <= run_d;
         max_q <= max_d;
      end
   end

   assign pix_count = cnt_q;
   assign max_stall = max_q;
`endif

endmodule

// File: tb/tb_tri_bbox_scanner.sv
// Directed bench for tri_bbox_scanner; stats checks compile in with
// TRI_SCAN_STATS_EN.
module tb_tri_bbox_scanner;

   localparam int CW = 11;

   logic          clk, rst_n;
   logic          tri_valid, tri_ready;
   logic [CW-1:0] x1, y1, x2, y2, x3, y3;
   logic [CW-1:0] tri_x1, tri_y1, tri_x2, tri_y2, tri_x3, tri_y3;
   logic          pix_valid, pix_ready, pix_last, busy, done;
   logic [CW-1:0] pix_x, pix_y;
`ifdef TRI_SCAN_STATS_EN
   logic [2*CW-1:0] pix_count;
   logic [15:0]     max_stall;
`endif

   int checks = 0;
   int errors = 0;

   tri_bbox_scanner dut (
      .clk(clk), .rst_n(rst_n),
      .tri_valid(tri_valid), .tri_ready(tri_ready),
      .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
      .tri_x1(tri_x1), .tri_y1(tri_y1), .tri_x2(tri_x2),
      .tri_y2(tri_y2), .tri_x3(tri_x3), .tri_y3(tri_y3),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last),
      .busy(busy),
`ifdef TRI_SCAN_STATS_EN
      .pix_count(pix_count), .max_stall(max_stall),
`endif
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Offer a triangle; returns at the SETUP cycle with vertices already
   // changed and tri_valid still high to show they are ignored.
   task automatic send(input int ax, input int ay, input int bx, input int by,
                       input int cx, input int cy);
      @(negedge clk);
      check("tri_ready_idle", 32'(tri_ready), 32'd1);
      x1 = CW'(ax); y1 = CW'(ay); x2 = CW'(bx); y2 = CW'(by);
      x3 = CW'(cx); y3 = CW'(cy);
      tri_valid = 1'b1;
      @(negedge clk);
      check("setup_busy", 32'(busy), 32'd1);
      check("setup_no_pix", 32'(pix_valid), 32'd0);
      check("setup_tri_x1", 32'(tri_x1), 32'(ax));
      check("setup_tri_y3", 32'(tri_y3), 32'(cy));
      x1 = CW'(999);
      y3 = CW'(999);
   endtask

   // Walk the expected box point by point. Optionally stalls sn cycles at
   // (sx,sy) or asserts reset on reaching (rx,ry).
   task automatic scan(input int ax, input int ay, input int cy,
                       input int minx, input int maxx, input int miny, input int maxy,
                       input int sx, input int sy, input int sn,
                       input int rx, input int ry);
      bit aborted = 1'b0;
      @(negedge clk);
      tri_valid = 1'b0;
      check("first_pix_valid", 32'(pix_valid), 32'd1);
      check("tri_x1_held", 32'(tri_x1), 32'(ax));
      for (int y = miny; y <= maxy && !aborted; y++) begin
         for (int x = minx; x <= maxx && !aborted; x++) begin
            if (x == rx && y == ry) begin
               check("pre_reset_pix", {pix_x, pix_y}, {21'd0, CW'(x), CW'(y)} );
               rst_n = 1'b0;
               #1;
               check("rst_pix_valid", 32'(pix_valid), 32'd0);
               check("rst_busy", 32'(busy), 32'd0);
               check("rst_pix_x", 32'(pix_x), 32'd0);
               check("rst_tri_x1", 32'(tri_x1), 32'd0);
               @(negedge clk);
               check("rst_no_done", 32'(done), 32'd0);
               rst_n = 1'b1;
               @(negedge clk);
               check("post_rst_done", 32'(done), 32'd0);
               check("post_rst_ready", 32'(tri_ready), 32'd1);
               aborted = 1'b1;
            end else begin
               check("pix_xy", {10'd0, pix_x, pix_y}, {10'd0, CW'(x), CW'(y)});
               check("pix_valid", 32'(pix_valid), 32'd1);
               check("pix_last", 32'(pix_last), 32'(x == maxx && y == maxy));
               check("no_done_scan", 32'(done), 32'd0);
               if (x == sx && y == sy) begin
                  for (int k = 0; k < sn; k++) begin
                     pix_ready = 1'b0;
                     @(negedge clk);
                     check("stall_xy", {10'd0, pix_x, pix_y}, {10'd0, CW'(x), CW'(y)});
                     check("stall_valid", 32'(pix_valid), 32'd1);
                     check("stall_tri_y3", 32'(tri_y3), 32'(cy));
                  end
                  pix_ready = 1'b1;
               end
               @(negedge clk);
            end
         end
      end
      if (!aborted) begin
         check("end_done", 32'(done), 32'd1);
         check("end_pix_valid", 32'(pix_valid), 32'd0);
         check("end_tri_ready", 32'(tri_ready), 32'd1);
         check("end_busy", 32'(busy), 32'd0);
`ifdef TRI_SCAN_STATS_EN
         check("pix_count", 32'(pix_count), 32'((maxx - minx + 1) * (maxy - miny + 1)));
         check("max_stall", 32'(max_stall), 32'(sn));
`endif
         @(negedge clk);
         check("done_one_cycle", 32'(done), 32'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0; tri_valid = 1'b0; pix_ready = 1'b1;
      x1 = '0; y1 = '0; x2 = '0; y2 = '0; x3 = '0; y3 = '0;
      repeat (2) @(negedge clk);
      check("rst_tri_ready", 32'(tri_ready), 32'd1);
      check("rst_pix_valid0", 32'(pix_valid), 32'd0);
      check("rst_pix_last", 32'(pix_last), 32'd0);
      check("rst_busy0", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pix_xy", {10'd0, pix_x, pix_y}, 32'd0);
      check("rst_tri_all", {tri_x1, tri_y1, tri_x2}, 33'd0);
      check("rst_tri_rest", {tri_y2, tri_x3, tri_y3}, 33'd0);
      rst_n = 1'b1;

      // Triangle 1, full speed: 5x11 = 55 points
      send(10, 10, 12, 20, 14, 11);
      scan(10, 10, 11, 10, 14, 10, 20, -1, -1, 0, -1, -1);

      // Coincident vertices: single point
      send(5, 5, 5, 5, 5, 5);
      scan(5, 5, 5, 5, 5, 5, 5, -1, -1, 0, -1, -1);

      // Clipped in x: 600..639 x 50..100
      send(700, 100, 600, 50, 650, 90);
      scan(700, 100, 90, 600, 639, 50, 100, -1, -1, 0, -1, -1);

      // Entirely off-screen in x: empty box
      send(650, 10, 700, 20, 660, 30);
      @(negedge clk);
      tri_valid = 1'b0;
      check("empty_done", 32'(done), 32'd1);
      check("empty_pix_valid", 32'(pix_valid), 32'd0);
      check("empty_tri_ready", 32'(tri_ready), 32'd1);
      @(negedge clk);
      check("empty_done_clear", 32'(done), 32'd0);
      check("empty_pix_valid2", 32'(pix_valid), 32'd0);

      // Triangle 1 with a 3-cycle stall at (11,10)
      send(10, 10, 12, 20, 14, 11);
      scan(10, 10, 11, 10, 14, 10, 20, 11, 10, 3, -1, -1);

      // Reset mid-scan at (12,15), then a fresh triangle
      send(10, 10, 12, 20, 14, 11);
      scan(10, 10, 11, 10, 14, 10, 20, -1, -1, 0, 12, 15);
      send(3, 7, 4, 7, 3, 8);
      scan(3, 7, 8, 3, 4, 7, 8, -1, -1, 0, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
